// File: rtl/lsu_mem_bridge_pkg.sv
// Shared types and helpers for the LSU-to-memory bridge.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (split doubleword-crossing
// accesses into two beats). When it is undefined, the lane shifters only
// span one doubleword.
package lsu_mem_pkg;

    localparam int DW_BYTES = 8;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int SPAN_BYTES = 2 * DW_BYTES;
`else
    localparam int SPAN_BYTES = DW_BYTES;
`endif
    localparam int SPAN_BITS = SPAN_BYTES * 8;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_X
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        RESP
    } state_e;

    // Byte-enable pattern for an LSB-aligned access of the given size.
    function automatic logic [3:0] be_pattern(input size_e size);
        case (size)
            SZ_B:    be_pattern = 4'b0001;
            SZ_H:    be_pattern = 4'b0011;
            SZ_W:    be_pattern = 4'b1111;
            default: be_pattern = 4'b0000;
        endcase
    endfunction

    // Turn one enable bit per byte lane into a per-bit write mask.
    function automatic logic [63:0] mask_expand(input logic [7:0] be);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/lsu_mem_bridge_rd_align.sv
// Read-data alignment: shifts the returned beat(s) down by the byte offset,
// picks byte/half/word and sign- or zero-extends to 32 bits.
// Honours LSU_MISALIGN_SPLIT_EN through the width of the beats input.
module lsu_rd_align
    import lsu_mem_pkg::*;
(
    input  logic [SPAN_BITS-1:0] beats,
    input  logic [2:0]           off,
    input  size_e                size,
    input  logic                 is_unsigned,
    output logic [31:0]          result
);

    logic [31:0] r;

    // Shift the addressed bytes to bit 0, then extend by access size.
    always_comb begin
        r      = 32'(beats >> {off, 3'b000});
        result = r;
        case (size)
            SZ_B:    result = {{24{~is_unsigned & r[7]}}, r[7:0]};
            SZ_H:    result = {{16{~is_unsigned & r[15]}}, r[15:0]};
            default: result = r;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Bridge from the RV32 load/store unit to the 64-bit synchronous memory.
// One request in flight; byte/half/word accesses become doubleword beats.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When defined, accesses that
// cross a doubleword are split into two beats; otherwise they are rejected
// with resp_err.
module lsu_mem_bridge
    import lsu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  ncs,
    output logic                  nwe,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] wmask,
    input  logic [DATA_WIDTH-1:0] rdata
);

    state_e state, state_n;

    // request-side lane preparation
    size_e                 req_size_e;
    logic [2:0]            req_off;
    logic [3:0]            req_be;
    logic [3:0]            req_bytes;
    logic [31:0]           req_data;
    logic                  crossing;
    logic                  req_err;
    logic [SPAN_BITS-1:0]  lane_data;
    logic [SPAN_BYTES-1:0] lane_be;

    // request context held for the whole transaction
    logic                  we_q;
    logic [2:0]            off_q;
    size_e                 size_q;
    logic                  uns_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic                  split_q;
    logic [28:0]           base_q;
    logic [63:0]           data_hi_q;
    logic [7:0]            mask_hi_q;
    logic [63:0]           beat0_q;
`endif

    // next values of the registered outputs
    logic                  ncs_n;
    logic                  nwe_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [DATA_WIDTH-1:0] wmask_n;
    logic                  resp_valid_n;
    logic                  resp_err_n;
    logic [31:0]           resp_rdata_n;

    logic [SPAN_BITS-1:0]  align_beats;
    logic [31:0]           align_result;

    assign req_ready = (state == IDLE);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign align_beats = (state == WAIT1) ? {rdata, beat0_q} : {64'b0, rdata};
`else
    assign align_beats = rdata;
`endif

    lsu_rd_align u_rd_align (
        .beats       (align_beats),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (align_result)
    );

    // Place incoming store data and byte enables onto memory lanes and classify the request.
    always_comb begin
        req_size_e = size_e'(req_size);
        req_off    = req_addr[2:0];
        req_be     = be_pattern(req_size_e);
        req_bytes  = 4'd1 << req_size;
        req_data   = req_wdata & {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
        crossing   = ({1'b0, req_off} + req_bytes) > 4'd8;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_err    = (req_size_e == SZ_X);
`else
        req_err    = (req_size_e == SZ_X) || crossing;
`endif
        lane_data  = SPAN_BITS'(req_data) << {req_off, 3'b000};
        lane_be    = SPAN_BYTES'(req_be) << req_off;
    end

    // Next-state logic; memory and response outputs are computed here and registered below.
    always_comb begin
        state_n      = state;
        ncs_n        = 1'b1;
        nwe_n        = 1'b1;
        addr_n       = addr;
        wdata_n      = wdata;
        wmask_n      = '0;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n = ISSUE0;
                        ncs_n   = 1'b0;
                        nwe_n   = ~req_we;
                        addr_n  = ADDR_WIDTH'({req_addr[31:3], 3'b000});
                        wdata_n = lane_data[DATA_WIDTH-1:0];
                        wmask_n = mask_expand(lane_be[7:0]);
                    end
                end
            end
            ISSUE0: begin
                if (!we_q) begin
                    state_n = WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
                end else if (split_q) begin
                    state_n = ISSUE1;
                    ncs_n   = 1'b0;
                    nwe_n   = 1'b0;
                    addr_n  = ADDR_WIDTH'({base_q + 29'd1, 3'b000});
                    wdata_n = data_hi_q;
                    wmask_n = mask_expand(mask_hi_q);
`endif
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                end
            end
            WAIT0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    state_n = ISSUE1;
                    ncs_n   = 1'b0;
                    nwe_n   = 1'b1;
                    addr_n  = ADDR_WIDTH'({base_q + 29'd1, 3'b000});
                    wdata_n = data_hi_q;
                    wmask_n = mask_expand(mask_hi_q);
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = align_result;
                end
`else
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = align_result;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ISSUE1: begin
                if (we_q) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                end else begin
                    state_n = WAIT1;
                end
            end
            WAIT1: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = align_result;
            end
`endif
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register and registered memory/response outputs; reset abandons any beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ncs        <= 1'b1;
            nwe        <= 1'b1;
            addr       <= '0;
            wdata      <= '0;
            wmask      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            ncs        <= ncs_n;
            nwe        <= nwe_n;
            addr       <= addr_n;
            wdata      <= wdata_n;
            wmask      <= wmask_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
        end
    end

    // Capture request context at accept, and the first read beat of a split load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            off_q     <= '0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q   <= 1'b0;
            base_q    <= '0;
            data_hi_q <= '0;
            mask_hi_q <= '0;
            beat0_q   <= '0;
`endif
        end else begin
            if (req_valid && req_ready) begin
                we_q      <= req_we;
                off_q     <= req_off;
                size_q    <= req_size_e;
                uns_q     <= req_unsigned;
`ifdef LSU_MISALIGN_SPLIT_EN
                split_q   <= crossing;
                base_q    <= req_addr[31:3];
                data_hi_q <= lane_data[127:64];
                mask_hi_q <= lane_be[15:8];
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state == WAIT0) begin
                beat0_q <= rdata;
            end
`endif
        end
    end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
Upstream bridge between the RV32 core's load/store unit and the 64-bit synchronous memory model, which has active-low `ncs`/`nwe`, a per-bit `wmask` and 1-cycle registered `rdata`. Converts one byte, half or word request into doubleword-aligned memory beats with lane placement and write masks. Extracts and sign/zero-extends read data. One request outstanding at a time.

Parameters:
ADDR_WIDTH, 32, memory byte-address width
DATA_WIDTH, 64, memory data width; only 64 is supported

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  bridge accepts a request (IDLE only)
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  load zero-extends when 1
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle response strobe; no back-pressure
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  illegal size, or crossing access without split support
ncs  out  1  memory chip select, active low
nwe  out  1  memory write enable, active low
addr  out  ADDR_WIDTH  doubleword-aligned byte address, {ea[31:3],3'b0}
wdata  out  DATA_WIDTH  lane-placed store data
wmask  out  DATA_WIDTH  8'hFF per enabled byte lane, 8'h00 otherwise
rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read strobe

Behaviour:
- Reset (async, any state): state=IDLE; ncs=1; nwe=1; addr=0; wdata=0; wmask=0; resp_valid=0; resp_rdata=0; resp_err=0; req_ready=1. An in-flight beat is abandoned, and a half-done split store leaves memory partially written.
- All memory-side outputs and all resp_* outputs are registered. req_ready is 1 only in IDLE.
- Accept happens when req_valid&&req_ready at a posedge; call this cycle 0. Request fields are latched at accept.
- Lanes: off=req_addr[2:0]; byte-enable pattern be = 1, 3 or F (size 0, 1, 2).
  - Form 128-bit values {64'b0,wdata} << off*8 and a 16-bit be << off.
  - Beat0 uses the low half; beat1 uses the high half at addr+8.
  - An access crosses when off + (1<<size) > 8.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - ISSUE*: ncs=0 for exactly one cycle. nwe=0 for a store, 1 for a load.
  - WAIT*: ncs=1; rdata is captured at the end of this cycle.
  - All other states: ncs=1, nwe=1, wmask=0.
- Aligned load: ISSUE0 (1) -> WAIT0 (2) -> RESP (3). resp_valid=1 in cycle 3.
- Aligned store: ISSUE0 (1) -> RESP (2). There is no WAIT state.
- Split load: ISSUE0, WAIT0, ISSUE1, WAIT1, RESP; resp_valid=1 in cycle 5.
- Split store: ISSUE0, ISSUE1, RESP; resp_valid=1 in cycle 3.
- Load result:
  - r = {beat1,beat0} >> off*8. beat1=0 when not split.
  - Take r[7:0], r[15:0] or r[31:0] by size.
  - Zero-extend if req_unsigned, else sign-extend. req_unsigned is ignored for words.
- Error path: size=3, or crossing without the optional feature, goes IDLE -> RESP directly. resp_valid=1 and resp_err=1 in cycle 1; no memory strobe; resp_rdata=0.
- RESP always returns to IDLE. The earliest next accept is the cycle after resp_valid.
- Misaligned accesses that stay within one doubleword are legal and single-beat.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined: crossing accesses are split into two beats as described above.
- Undefined: crossing accesses return resp_err=1 via the error path. ISSUE1/WAIT1 and the upper 64 bits of the shifters are not synthesised.

Decomposition:
- Package lsu_mem_pkg contains:
  - enum size_e {SZ_B, SZ_H, SZ_W, SZ_X}
  - enum state_e
  - DW_BYTES=8
  - function be_pattern(size_e) returning 4'b0001, 4'b0011 or 4'b1111
  - function mask_expand(8-bit be) returning the 64-bit mask
- Sub-module lsu_rd_align: combinational shift and extend. Inputs {beat1,beat0}, off, size, unsigned; output 32-bit result.

Test Plan:
- Reset: assert rst mid-WAIT0 -> immediately ncs=1, nwe=1, wmask=0, resp_valid=0. After release, req_ready=1 and no stale response appears.
- Word store 0x104 data 0xDEADBEEF -> cycle 1: ncs=0, nwe=0, addr=0x100, wdata[63:32]=0xDEADBEEF, wmask=64'hFFFFFFFF_00000000. Cycle 2: resp_valid=1, resp_err=0.
- Byte load 0x107 signed -> cycle 3 resp_rdata=0xFFFFFFDE. Unsigned -> 0x000000DE. Half load 0x106 signed -> 0xFFFFDEAD.
- With LSU_MISALIGN_SPLIT_EN, word store 0x106 data 0x11223344:
  - Beat0: addr 0x100, wmask 64'hFFFF0000_00000000, wdata[63:48]=0x3344.
  - Beat1: addr 0x108, wmask 64'h0000FFFF, wdata[15:0]=0x1122.
  - resp_valid at cycle 3. Word load 0x106 -> 0x11223344 at cycle 5.
- Without LSU_MISALIGN_SPLIT_EN, word load 0x106 -> resp_err=1 in cycle 1, ncs never low.
- req_size=3 with req_valid held high -> resp_err=1, resp_rdata=0 in cycle 1. Re-accept happens in cycle 2, and req_ready=0 in cycle 1.
